// File: rtl/seq_sub_64bit.sv
// Multi-cycle subtractor: diff = in1 - in2 - bin, one CHUNK-bit slice per clock
// via a + ~b + ~bin, with a start/busy/done handshake.
module seq_sub_64bit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  input  logic             start,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a, nb, acc, acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] a_sl, nb_sl, s;
  logic             c;
  logic             last;
  logic             ovf_next;

  // Slice select and write-back use constant part-selects so any CHUNK divides cleanly.
  always_comb begin
    a_sl     = '0;
    nb_sl    = '0;
    acc_next = acc;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CW'(i)) begin
        a_sl  = a[i*CHUNK +: CHUNK];
        nb_sl = nb[i*CHUNK +: CHUNK];
      end
    end
    {c, s} = {1'b0, a_sl} + {1'b0, nb_sl} + {{CHUNK{1'b0}}, carry};
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CW'(i)) acc_next[i*CHUNK +: CHUNK] = s;
    end
    last = (cnt == CW'(NCHUNK - 1));
    // nb holds ~in2, so equal MSBs of a and nb mean the operand signs differ.
    ovf_next = (a[WIDTH-1] == nb[WIDTH-1]) && (acc_next[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      nb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a     <= in1;
            nb    <= ~in2;
            carry <= ~bin;
            cnt   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= c;
          if (last) begin
            cnt  <= '0;
            diff <= acc_next;
            bout <= ~c;
            ovf  <= ovf_next;
            done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sub_64bit.sv
// Self-checking bench for seq_sub_64bit: transaction-level model compared every
// cycle, plus directed literal cases, reset abort and random traffic.
module tb_seq_sub_64bit;

  localparam int NCHUNK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] in1 = '0;
  logic [63:0] in2 = '0;
  logic        bin = 1'b0;
  logic        start = 1'b0;
  logic [63:0] diff;
  logic        bout, ovf, busy, done;

  int checks = 0;
  int errors = 0;

  // Model state: one pending op, released NCHUNK edges after acceptance.
  logic [63:0] m_diff = '0;
  logic        m_bout = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [65:0] m_pend = '0;
  int          m_left = 0;
  int          m_ops = 0;

  seq_sub_64bit #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .bin(bin), .start(start),
    .diff(diff), .bout(bout), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Returns {ovf, bout, diff} from plain 65-bit unsigned and 66-bit signed arithmetic.
  function automatic logic [65:0] ref_sub(input logic [63:0] x, input logic [63:0] y, input logic b);
    logic [64:0]        u;
    logic signed [65:0] sr;
    logic               ov;
    u  = {1'b0, x} - {1'b0, y} - {64'd0, b};
    sr = $signed({x[63], x[63], x}) - $signed({y[63], y[63], y}) - $signed({65'd0, b});
    ov = !(sr[65:63] == 3'b000 || sr[65:63] == 3'b111);
    return {ov, u[64], u[63:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_diff <= '0; m_bout <= 1'b0; m_ovf <= 1'b0;
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_diff <= m_pend[63:0];
          m_bout <= m_pend[64];
          m_ovf  <= m_pend[65];
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_pend <= ref_sub(in1, in2, bin);
        m_busy <= 1'b1;
        m_left <= NCHUNK;
        m_ops  <= m_ops + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {63'd0, busy}, {63'd0, m_busy});
    check("done", {63'd0, done}, {63'd0, m_done});
    check("diff", diff, m_diff);
    check("bout", {63'd0, bout}, {63'd0, m_bout});
    check("ovf",  {63'd0, ovf},  {63'd0, m_ovf});
  end

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy; k++) begin
      @(posedge clk); #2;
    end
    if (busy) begin
      errors++;
      $display("[TB] FAIL idle_timeout: busy still 1 expected 0");
    end
  endtask

  // Issues one op, scrambles inputs and pokes start while busy, waits for done.
  task automatic applyStimulus(input logic [63:0] x, input logic [63:0] y, input logic b);
    int k;
    wait_idle();
    in1 = x; in2 = y; bin = b; start = 1'b1;
    @(posedge clk); #2;
    for (k = 1; k <= 20; k++) begin
      in1 = rand64(); in2 = rand64(); bin = 1'($urandom); start = 1'($urandom);
      @(posedge clk); #2;
      if (done) break;
    end
    start = 1'b0;
    check("latency", 64'(k), 64'(NCHUNK));
  endtask

  task automatic checkOutput(input string name, input logic [63:0] x, input logic [63:0] y, input logic b,
                             input logic [63:0] ed, input logic eb, input logic eo);
    logic [65:0] r;
    r = ref_sub(x, y, b);
    check({name, "_model"}, r[63:0], ed);
    check({name, "_model_flags"}, {62'd0, r[65], r[64]}, {62'd0, eo, eb});
    check({name, "_diff"}, diff, ed);
    check({name, "_bout"}, {63'd0, bout}, {63'd0, eb});
    check({name, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
  endtask

  task automatic run_directed(input string name, input logic [63:0] x, input logic [63:0] y, input logic b,
                              input logic [63:0] ed, input logic eb, input logic eo);
    applyStimulus(x, y, b);
    checkOutput(name, x, y, b, ed, eb, eo);
  endtask

  initial begin
    int gap, seen, cyc, target;
    logic saw_done;
    #1 rst = 1'b1;
    #1;
    check("rst_diff", diff, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;

    run_directed("basic", 64'd100, 64'd58, 1'b0, 64'd42, 1'b0, 1'b0);
    run_directed("borrow_all", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_directed("borrow_up", 64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_directed("equal_bin", 64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_directed("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                 64'h8000_0000_0000_0000, 1'b1, 1'b1);
    run_directed("bin_ovf", 64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);

    // Abort after two slices: outputs clear at once and no done follows.
    wait_idle();
    in1 = rand64(); in2 = rand64(); bin = 1'b0; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_diff", diff, 64'd0);
    check("abort_flags", {61'd0, bout, ovf, done}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);

    // Start held high: a new op is accepted on the edge right after each done.
    in1 = rand64(); in2 = rand64(); bin = 1'($urandom); start = 1'b1;
    gap = 0; seen = 0;
    for (int k = 0; k < 60 && seen < 6; k++) begin
      @(posedge clk); #2;
      gap++;
      if (done) begin
        if (seen > 0) check("b2b_gap", 64'(gap), 64'(NCHUNK + 1));
        seen++;
        gap = 0;
        in1 = rand64(); in2 = rand64(); bin = 1'($urandom);
      end
    end
    check("b2b_count", 64'(seen), 64'd6);
    start = 1'b0;
    wait_idle();

    // Random traffic, start asserted most cycles so many requests land while busy.
    target = m_ops + 10000;
    cyc = 0;
    while (m_ops < target && cyc < 80000) begin
      case ($urandom_range(7))
        0: begin in1 = rand64(); in2 = in1; end
        1: begin in1 = 64'd0; in2 = rand64(); end
        2: begin in1 = rand64(); in2 = 64'hFFFF_FFFF_FFFF_FFFF; end
        default: begin in1 = rand64(); in2 = rand64(); end
      endcase
      bin = 1'($urandom);
      start = ($urandom_range(3) != 0);
      @(posedge clk); #2;
      cyc++;
    end
    if (m_ops < target) begin
      errors++;
      $display("[TB] FAIL random_budget: ops %0d expected %0d", m_ops, target);
    end
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
